// File: rtl/rps_scoreboard.sv
// Rock-paper-scissors match scoreboard: arms the upstream game, scores each round, ends the match on a win target or round cap.
// Round latency 4 cycles minimum (ARM..SCORE); waits on upstream ready handshake indefinitely, no timeout.
module rps_scoreboard #(
   parameter int WIN_TARGET = 3,
   parameter int MAX_ROUNDS = 9,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_match,
   input  logic [1:0]       result,
   input  logic             ready,
   output logic             start,
   output logic [CNT_W-1:0] p1_score,
   output logic [CNT_W-1:0] p2_score,
   output logic [CNT_W-1:0] tie_count,
   output logic [CNT_W-1:0] round_count,
   output logic             round_valid,
   output logic             match_over,
   output logic [1:0]       winner
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT_LO, S_WAIT_HI, S_SCORE, S_DONE
   } state_t;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;
   localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_TARGET);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ROUNDS);

   state_t           state_q, state_d;
   logic [1:0]       res_q, res_d;
   logic [CNT_W-1:0] p1_q, p1_d, p2_q, p2_d, tie_q, tie_d, rc_q, rc_d;
   logic [1:0]       winner_q, winner_d;
   logic             start_q, start_d, round_valid_q, round_valid_d, match_over_q, match_over_d;
   logic [CNT_W-1:0] p1_inc, p2_inc, tie_inc, rc_inc;
   logic             hit_p1, hit_p2, hit_cap;

   // Post-increment tallies for the round held in res_q; the exit decision in SCORE uses these.
   always_comb begin
      p1_inc  = p1_q;
      p2_inc  = p2_q;
      tie_inc = tie_q;
      rc_inc  = rc_q + 1'b1;
      case (res_q)
         RES_P1:  p1_inc  = p1_q + 1'b1;
         RES_P2:  p2_inc  = p2_q + 1'b1;
         default: tie_inc = tie_q + 1'b1;
      endcase
      hit_p1  = (p1_inc == WIN_CNT);
      hit_p2  = (p2_inc == WIN_CNT);
      hit_cap = (rc_inc == MAX_CNT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         res_q         <= RES_NONE;
         p1_q          <= '0;
         p2_q          <= '0;
         tie_q         <= '0;
         rc_q          <= '0;
         winner_q      <= WIN_NONE;
         start_q       <= 1'b0;
         round_valid_q <= 1'b0;
         match_over_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         res_q         <= res_d;
         p1_q          <= p1_d;
         p2_q          <= p2_d;
         tie_q         <= tie_d;
         rc_q          <= rc_d;
         winner_q      <= winner_d;
         start_q       <= start_d;
         round_valid_q <= round_valid_d;
         match_over_q  <= match_over_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (new_match) begin
         state_d = S_ARM;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_IDLE;
            S_ARM:     state_d = S_WAIT_LO;
            // A still-high ready here belongs to the previous round.
            S_WAIT_LO: if (!ready) state_d = S_WAIT_HI;
            S_WAIT_HI: if (ready && result != RES_NONE) state_d = S_SCORE;
            S_SCORE:   state_d = (hit_p1 || hit_p2 || hit_cap) ? S_DONE : S_ARM;
            S_DONE:    state_d = S_DONE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      res_d    = res_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      tie_d    = tie_q;
      rc_d     = rc_q;
      winner_d = winner_q;
      if (new_match) begin
         res_d    = RES_NONE;
         p1_d     = '0;
         p2_d     = '0;
         tie_d    = '0;
         rc_d     = '0;
         winner_d = WIN_NONE;
      end else if (state_q == S_WAIT_HI && ready && result != RES_NONE) begin
         res_d = result;
      end else if (state_q == S_SCORE) begin
         p1_d  = p1_inc;
         p2_d  = p2_inc;
         tie_d = tie_inc;
         rc_d  = rc_inc;
         if (hit_p1)
            winner_d = WIN_P1;
         else if (hit_p2)
            winner_d = WIN_P2;
         else if (hit_cap)
            winner_d = (p1_inc > p2_inc) ? WIN_P1 : (p2_inc > p1_inc) ? WIN_P2 : WIN_DRAW;
      end
      // Pulses are registered from the next state, so each is high exactly while its state is occupied.
      start_d       = (state_d == S_ARM);
      round_valid_d = (state_d == S_SCORE);
      match_over_d  = (state_d == S_DONE);
   end

   assign start       = start_q;
   assign round_valid = round_valid_q;
   assign match_over  = match_over_q;
   assign winner      = winner_q;
   assign p1_score    = p1_q;
   assign p2_score    = p2_q;
   assign tie_count   = tie_q;
   assign round_count = rc_q;

endmodule

// File: tb/tb_rps_scoreboard.sv
// Directed bench for rps_scoreboard: default instance plus a WIN_TARGET=5 instance for the round-cap-with-lead case.
module tb_rps_scoreboard;
   localparam int CNT_W = 4;
   localparam logic [1:0] NONE = 2'b00, P1 = 2'b01, P2 = 2'b10, TIE = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1, new_match = 1'b0, ready = 1'b0;
   logic [1:0] result = 2'b00;

   logic start, round_valid, match_over;
   logic [1:0] winner;
   logic [CNT_W-1:0] p1_score, p2_score, tie_count, round_count;
   logic start_b, round_valid_b, match_over_b;
   logic [1:0] winner_b;
   logic [CNT_W-1:0] p1_score_b, p2_score_b, tie_count_b, round_count_b;

   int vectors = 0, miscompares = 0, start_cnt = 0;

   always #5 clk = ~clk;

   rps_scoreboard dut (
      .clk(clk), .rst(rst), .new_match(new_match), .result(result), .ready(ready),
      .start(start), .p1_score(p1_score), .p2_score(p2_score), .tie_count(tie_count),
      .round_count(round_count), .round_valid(round_valid), .match_over(match_over), .winner(winner)
   );

   rps_scoreboard #(.WIN_TARGET(5), .MAX_ROUNDS(9), .CNT_W(CNT_W)) dut_b (
      .clk(clk), .rst(rst), .new_match(new_match), .result(result), .ready(ready),
      .start(start_b), .p1_score(p1_score_b), .p2_score(p2_score_b), .tie_count(tie_count_b),
      .round_count(round_count_b), .round_valid(round_valid_b), .match_over(match_over_b), .winner(winner_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      if (start === 1'b1) start_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_tally(input string tag, input int p1, input int p2, input int tie,
                            input int rc, input logic [1:0] win, input logic mo);
      chk({tag, ".p1_score"},    32'(p1_score),    32'(p1));
      chk({tag, ".p2_score"},    32'(p2_score),    32'(p2));
      chk({tag, ".tie_count"},   32'(tie_count),   32'(tie));
      chk({tag, ".round_count"}, 32'(round_count), 32'(rc));
      chk({tag, ".winner"},      32'(winner),      32'(win));
      chk({tag, ".match_over"},  32'(match_over),  32'(mo));
   endtask

   task automatic wait_start(input bit use_b);
      for (int i = 0; i < 20; i++) begin
         if ((use_b ? start_b : start) === 1'b1) break;
         tick();
      end
      chk("start_seen", 32'(use_b ? start_b : start), 32'd1);
   endtask

   // One round at minimum latency: ready low through ARM and WAIT_LO, outcome presented in WAIT_HI.
   task automatic play_round(input logic [1:0] r, input bit use_b);
      wait_start(use_b);
      ready = 1'b0; result = NONE;
      tick();
      tick();
      ready = 1'b1; result = r;
      tick();
      chk("round_valid_in_score", 32'(use_b ? round_valid_b : round_valid), 32'd1);
      ready = 1'b0; result = NONE;
      tick();
   endtask

   initial begin
      int  sc;
      logic seen_rv, seen_st;

      // Reset, then idle outputs hold until new_match
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("reset.start", 32'(start), 32'd0);
      chk("reset.round_valid", 32'(round_valid), 32'd0);
      chk_tally("reset", 0, 0, 0, 0, 2'b00, 1'b0);

      // P1 sweep
      start_cnt = 0;
      new_match = 1'b1; tick(); new_match = 1'b0;
      play_round(P1, 1'b0);
      chk("latency4.start_after_score", 32'(start), 32'd1);
      chk_tally("sweep_r1", 1, 0, 0, 1, 2'b00, 1'b0);
      play_round(P1, 1'b0);
      play_round(P1, 1'b0);
      chk_tally("sweep", 3, 0, 0, 3, 2'b01, 1'b1);
      chk("sweep.start_pulses", 32'(start_cnt), 32'd3);

      // DONE hold under input activity
      sc = start_cnt; seen_rv = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ready = i[0]; result = i[1:0];
         tick();
         seen_rv |= round_valid;
      end
      ready = 1'b0; result = NONE;
      chk_tally("done_hold", 3, 0, 0, 3, 2'b01, 1'b1);
      chk("done_hold.start_pulses", 32'(start_cnt), 32'(sc));
      chk("done_hold.round_valid_seen", 32'(seen_rv), 32'd0);

      // Mixed match won by P2
      new_match = 1'b1; tick(); new_match = 1'b0;
      play_round(TIE, 1'b0);
      play_round(P2, 1'b0);
      play_round(P1, 1'b0);
      play_round(P2, 1'b0);
      chk_tally("mixed_r4", 1, 2, 1, 4, 2'b00, 1'b0);
      play_round(P2, 1'b0);
      chk_tally("mixed", 1, 3, 1, 5, 2'b10, 1'b1);

      // Round cap with all ties
      new_match = 1'b1; tick(); new_match = 1'b0;
      for (int i = 0; i < 9; i++) play_round(TIE, 1'b0);
      chk_tally("cap_ties", 0, 0, 9, 9, 2'b11, 1'b1);

      // Round cap with a P1 lead, on the WIN_TARGET=5 instance
      new_match = 1'b1; tick(); new_match = 1'b0;
      for (int i = 0; i < 4; i++) play_round(P1, 1'b1);
      for (int i = 0; i < 5; i++) play_round(TIE, 1'b1);
      chk("cap_lead.p1_score", 32'(p1_score_b), 32'd4);
      chk("cap_lead.tie_count", 32'(tie_count_b), 32'd5);
      chk("cap_lead.round_count", 32'(round_count_b), 32'd9);
      chk("cap_lead.winner", 32'(winner_b), 32'd1);
      chk("cap_lead.match_over", 32'(match_over_b), 32'd1);

      // Stale ready held through ARM, then a NONE result with ready high
      ready = 1'b1; result = P1;
      new_match = 1'b1; tick(); new_match = 1'b0;
      chk("stale.start", 32'(start), 32'd1);
      seen_rv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen_rv |= round_valid;
      end
      chk("stale.round_valid_seen", 32'(seen_rv), 32'd0);
      chk("stale.round_count", 32'(round_count), 32'd0);
      ready = 1'b0; result = NONE;
      tick();
      ready = 1'b1; result = NONE;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen_rv |= round_valid;
      end
      chk("none_ignored.round_valid_seen", 32'(seen_rv), 32'd0);
      chk("none_ignored.round_count", 32'(round_count), 32'd0);
      result = P2;
      tick();
      chk("stale.round_valid", 32'(round_valid), 32'd1);
      ready = 1'b0; result = NONE;
      tick();
      chk_tally("stale", 0, 1, 0, 1, 2'b00, 1'b0);

      // Mid-match abort by new_match after 2 rounds, taken from WAIT_LO
      play_round(P1, 1'b0);
      chk_tally("pre_abort", 1, 1, 0, 2, 2'b00, 1'b0);
      tick();
      chk("pre_abort.start_low", 32'(start), 32'd0);
      new_match = 1'b1; tick(); new_match = 1'b0;
      chk("abort.start", 32'(start), 32'd1);
      chk_tally("abort", 0, 0, 0, 0, 2'b00, 1'b0);

      // rst while in WAIT_HI with an outcome on the inputs
      play_round(P1, 1'b0);
      chk_tally("pre_rst", 1, 0, 0, 1, 2'b00, 1'b0);
      ready = 1'b0; result = NONE;
      tick(); tick();
      ready = 1'b1; result = P1; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst.round_valid", 32'(round_valid), 32'd0);
      chk("rst.start", 32'(start), 32'd0);
      chk_tally("rst", 0, 0, 0, 0, 2'b00, 1'b0);
      seen_rv = 1'b0; seen_st = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen_rv |= round_valid;
         seen_st |= start;
      end
      chk("post_rst.round_valid_seen", 32'(seen_rv), 32'd0);
      chk("post_rst.start_seen", 32'(seen_st), 32'd0);
      chk_tally("post_rst", 0, 0, 0, 0, 2'b00, 1'b0);
      ready = 1'b0; result = NONE;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
